fetch_scheduler: RTL and testbench

FETCH_SCHEDULER -- requirements
Module: fetch_scheduler

---
 rtl/fetch_scheduler_pkg.sv | 36 +++
 rtl/fetch_scheduler_rr.sv | 21 ++
 rtl/fetch_scheduler.sv | 163 ++++++++++++++++
 tb/tb_fetch_scheduler.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_scheduler_pkg.sv
// Shared types and constants for the fetch scheduler: FSM states, requester
// indices and the datapath buffer-select codes.
package fetch_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RST_CNT,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int REQ_W = 0;
    localparam int REQ_I = 1;
    localparam int REQ_B = 2;

    localparam logic [2:0] BUF_WEIGHT = 3'b000;
    localparam logic [2:0] BUF_INPUT  = 3'b010;
    localparam logic [2:0] BUF_BIAS   = 3'b001;

    function automatic logic [2:0] buf_code(input logic [1:0] idx);
        case (idx)
            2'(REQ_I): return BUF_INPUT;
            2'(REQ_B): return BUF_BIAS;
            default:   return BUF_WEIGHT;
        endcase
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
        if (oh[REQ_B])      return 2'(REQ_B);
        else if (oh[REQ_I]) return 2'(REQ_I);
        else                return 2'(REQ_W);
    endfunction

endpackage

// File: rtl/fetch_scheduler_rr.sv
// rr_arbiter3: combinational 3-way round-robin; the requester after i_ptr
// has highest priority, the one at i_ptr the lowest.
module rr_arbiter3 (
    input  logic [1:0] i_ptr,
    input  logic [2:0] i_req,
    output logic [2:0] o_gnt
);
    logic [1:0] w_first;
    logic [1:0] w_second;
    logic [1:0] w_third;

    always_comb begin
        w_first  = (i_ptr    == 2'd2) ? 2'd0 : i_ptr    + 2'd1;
        w_second = (w_first  == 2'd2) ? 2'd0 : w_first  + 2'd1;
        w_third  = (w_second == 2'd2) ? 2'd0 : w_second + 2'd1;
        o_gnt    = 3'b000;
        if (i_req[w_first])       o_gnt[w_first]  = 1'b1;
        else if (i_req[w_second]) o_gnt[w_second] = 1'b1;
        else if (i_req[w_third])  o_gnt[w_third]  = 1'b1;
    end
endmodule

// File: rtl/fetch_scheduler.sv
// Fetch scheduler: arbitrates weight/input/bias fetch requests and sequences
// the datapath. Optional per-requester ping-pong select under FETCH_PINGPONG_EN.
module fetch_scheduler
    import fetch_scheduler_pkg::*;
#(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] tiles_sel,
    output logic [2:0] gnt,
    output logic [2:0] done,
    input  logic       fetch_done,
    output logic       start_fetch,
    output logic       reset_addr_counter,
    output logic [2:0] buffer_select,
    output logic       tiles_control,
    output logic       double_buffering,
    output logic       sched_busy,
    output logic       timeout_err
);
    localparam logic [3:0]  RST_LAST = 4'(RST_CYCLES - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    logic [1:0]  r_ptr;
    logic [1:0]  r_idx;
    logic [2:0]  r_gnt;
    logic [2:0]  r_done;
    logic        r_start;
    logic        r_rac;
    logic [2:0]  r_bsel;
    logic        r_tiles;
    logic        r_busy;
    logic        r_terr;
    logic        r_to_hit;
    logic [3:0]  r_cnt;
    logic [15:0] r_wcnt;
    logic [2:0]  w_gnt;
    logic [1:0]  w_idx;
`ifdef FETCH_PINGPONG_EN
    logic [2:0]  r_pp;
    logic        r_dbuf;
`endif

    rr_arbiter3 u_arb (
        .i_ptr (r_ptr),
        .i_req (req),
        .o_gnt (w_gnt)
    );

    assign w_idx = onehot_to_idx(w_gnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_ptr    <= 2'd2;
            r_idx    <= 2'd0;
            r_gnt    <= 3'b000;
            r_done   <= 3'b000;
            r_start  <= 1'b0;
            r_rac    <= 1'b0;
            r_bsel   <= BUF_WEIGHT;
            r_tiles  <= 1'b0;
            r_busy   <= 1'b0;
            r_terr   <= 1'b0;
            r_to_hit <= 1'b0;
            r_cnt    <= 4'd0;
            r_wcnt   <= 16'd0;
`ifdef FETCH_PINGPONG_EN
            r_pp     <= 3'b000;
            r_dbuf   <= 1'b0;
`endif
        end else begin
            r_done  <= 3'b000;
            r_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req != 3'b000) begin
                        r_state <= S_ARB;
                        r_busy  <= 1'b1;
                    end
                end
                S_ARB: begin
                    // A request withdrawn before arbitration simply returns to IDLE.
                    if (w_gnt != 3'b000) begin
                        r_gnt   <= w_gnt;
                        r_idx   <= w_idx;
                        r_bsel  <= buf_code(w_idx);
                        r_tiles <= tiles_sel[w_idx];
`ifdef FETCH_PINGPONG_EN
                        r_dbuf  <= r_pp[w_idx];
`endif
                        r_rac   <= 1'b1;
                        r_cnt   <= 4'd0;
                        r_state <= S_RST_CNT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_RST_CNT: begin
                    if (r_cnt == RST_LAST) begin
                        r_rac   <= 1'b0;
                        r_start <= 1'b1;
                        r_state <= S_START;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_START: begin
                    r_wcnt   <= 16'd0;
                    r_to_hit <= 1'b0;
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the last allowed cycle still counts as success.
                    if (fetch_done) begin
                        r_done  <= r_gnt;
                        r_state <= S_DONE;
                    end else if (r_wcnt == TO_LAST) begin
                        r_done   <= r_gnt;
                        r_terr   <= 1'b1;
                        r_to_hit <= 1'b1;
                        r_state  <= S_DONE;
                    end else begin
                        r_wcnt <= r_wcnt + 16'd1;
                    end
                end
                S_DONE: begin
                    r_ptr   <= r_idx;
                    r_gnt   <= 3'b000;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef FETCH_PINGPONG_EN
                    if (!r_to_hit) r_pp[r_idx] <= ~r_pp[r_idx];
`endif
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt                = r_gnt;
    assign done               = r_done;
    assign start_fetch        = r_start;
    assign reset_addr_counter = r_rac;
    assign buffer_select      = r_bsel;
    assign tiles_control      = r_tiles;
    assign sched_busy         = r_busy;
    assign timeout_err        = r_terr;
`ifdef FETCH_PINGPONG_EN
    assign double_buffering   = r_dbuf;
`else
    assign double_buffering   = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
// Self-checking bench for fetch_scheduler: directed table, timeout and reset
// sequences, plus randomized transactions against a transaction-level model.
module tb_fetch_scheduler;
    localparam int RSTC = 2;
    localparam int TO   = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] tiles_sel;
    logic       fetch_done;
    logic [2:0] gnt;
    logic [2:0] done;
    logic       start_fetch;
    logic       reset_addr_counter;
    logic [2:0] buffer_select;
    logic       tiles_control;
    logic       double_buffering;
    logic       sched_busy;
    logic       timeout_err;

    fetch_scheduler #(.RST_CYCLES(RSTC), .TIMEOUT_CYCLES(TO)) dut (
        .clk                (clk),
        .rst                (rst),
        .req                (req),
        .tiles_sel          (tiles_sel),
        .gnt                (gnt),
        .done               (done),
        .fetch_done         (fetch_done),
        .start_fetch        (start_fetch),
        .reset_addr_counter (reset_addr_counter),
        .buffer_select      (buffer_select),
        .tiles_control      (tiles_control),
        .double_buffering   (double_buffering),
        .sched_busy         (sched_busy),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int m_last = 2;
    bit m_pp [3];
    bit m_to = 1'b0;

    typedef struct {
        logic [2:0] r;
        logic [2:0] ts;
        int         dly;
        bit         stray;
        bit         drop;
        logic [2:0] exp_gnt;
        logic [2:0] exp_bsel;
        logic       exp_tiles;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int pick(input logic [2:0] r, input int last);
        for (int k = 1; k <= 3; k++) begin
            int i;
            i = (last + k) % 3;
            if (r[i]) return i;
        end
        return 0;
    endfunction

    function automatic logic [2:0] code_of(input int i);
        if (i == 0) return 3'b000;
        if (i == 1) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic pp_exp(input int i);
`ifdef FETCH_PINGPONG_EN
        return m_pp[i];
`else
        return 1'b0 & i[0];
`endif
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE; dly <= 0 means no fetch_done.
    task automatic txn(input logic [2:0] r, input logic [2:0] ts, input int dly,
                       input bit stray, input bit drop,
                       output logic [2:0] g_o, output logic [2:0] b_o, output logic t_o);
        int n;
        int idx;
        int rac;
        int sf;
        bit stable;
        bit to_exp;
        logic [2:0] g0, b0;
        logic t0, d0;
        to_exp = (dly <= 0);
        idx = pick(r, m_last);
        req = r;
        tiles_sel = ts;
        fetch_done = stray;
        n = 0;
        do begin
            @(posedge clk); #1;
            fetch_done = 1'b0;
            n++;
        end while (gnt == 3'b000 && n < 8);
        chk("gnt_latency", n, 2);
        g0 = gnt; b0 = buffer_select; t0 = tiles_control; d0 = double_buffering;
        g_o = g0; b_o = b0; t_o = t0;
        chk("gnt_model", g0, 3'b001 << idx);
        chk("bsel_model", b0, code_of(idx));
        chk("tiles_model", t0, ts[idx]);
        chk("dbuf_model", d0, pp_exp(idx));
        chk("busy_active", sched_busy, 1);
        rac = 0;
        n = 0;
        while (start_fetch == 1'b0 && n < 40) begin
            rac += int'(reset_addr_counter);
            if (stray && n == 0) fetch_done = 1'b1;
            @(posedge clk); #1;
            fetch_done = 1'b0;
            n++;
        end
        chk("rst_cnt_cycles", rac, RSTC);
        chk("start_after_gnt", n, RSTC);
        chk("rac_low_at_start", reset_addr_counter, 0);
        if (drop) begin
            req = r & ~g0;
            tiles_sel = ~ts;
        end
        sf = 1;
        stable = 1'b1;
        n = 0;
        while (done == 3'b000 && n < TO + 10) begin
            if (dly > 0 && n == dly) fetch_done = 1'b1;
            @(posedge clk); #1;
            fetch_done = 1'b0;
            n++;
            sf += int'(start_fetch);
            if (gnt !== g0 || buffer_select !== b0 || tiles_control !== t0 ||
                double_buffering !== d0 || sched_busy !== 1'b1)
                stable = 1'b0;
        end
        m_last = idx;
        if (!to_exp) m_pp[idx] = ~m_pp[idx];
        m_to = m_to | to_exp;
        chk("done_value", done, g0);
        chk("done_latency", n, to_exp ? TO + 1 : dly + 1);
        chk("start_pulses", sf, 1);
        chk("held_outputs", stable, 1);
        chk("timeout_flag", timeout_err, m_to);
        @(posedge clk); #1;
        chk("back_to_idle", {sched_busy, gnt, done}, 0);
    endtask

    vec_t tbl [7];
    logic [2:0] g, b;
    logic t;

    initial begin
        tbl[0] = '{3'b001, 3'b001, 20, 1'b0, 1'b0, 3'b001, 3'b000, 1'b1};
        tbl[1] = '{3'b111, 3'b000,  5, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0};
        tbl[2] = '{3'b111, 3'b100,  5, 1'b0, 1'b0, 3'b100, 3'b001, 1'b1};
        tbl[3] = '{3'b111, 3'b000,  5, 1'b0, 1'b0, 3'b001, 3'b000, 1'b0};
        tbl[4] = '{3'b110, 3'b010,  3, 1'b1, 1'b1, 3'b010, 3'b010, 1'b1};
        tbl[5] = '{3'b101, 3'b100,  7, 1'b0, 1'b0, 3'b100, 3'b001, 1'b1};
        tbl[6] = '{3'b011, 3'b001,  1, 1'b1, 1'b0, 3'b001, 3'b000, 1'b1};

        rst = 1'b1; req = 3'b000; tiles_sel = 3'b000; fetch_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_values", {gnt, done, start_fetch, reset_addr_counter, buffer_select,
                             tiles_control, double_buffering, sched_busy, timeout_err}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {sched_busy, gnt}, 0);

        for (int i = 0; i < 7; i++) begin
            txn(tbl[i].r, tbl[i].ts, tbl[i].dly, tbl[i].stray, tbl[i].drop, g, b, t);
            chk("tbl_gnt", g, tbl[i].exp_gnt);
            chk("tbl_bsel", b, tbl[i].exp_bsel);
            chk("tbl_tiles", t, tbl[i].exp_tiles);
        end

        // Timeout: no fetch_done at all
        txn(3'b010, 3'b010, 0, 1'b0, 1'b0, g, b, t);
        chk("timeout_sticky", timeout_err, 1);
        req = 3'b000;
        repeat (3) @(posedge clk);
        #1;
        chk("timeout_sticky_idle", timeout_err, 1);

        for (int i = 0; i < 16; i++) begin
            logic [2:0] rr, tt;
            int dd;
            rr = 3'($urandom_range(1, 7));
            tt = 3'($urandom_range(0, 7));
            dd = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO - 2));
            txn(rr, tt, dd, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), g, b, t);
        end
        req = 3'b000;
        @(posedge clk); #1;

        // Reset in the middle of WAIT aborts the transaction
        begin
            int n;
            bit seen;
            req = 3'b100; tiles_sel = 3'b100;
            n = 0;
            while (start_fetch == 1'b0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("abort_reached_start", start_fetch, 1);
            repeat (3) @(posedge clk);
            #1;
            rst = 1'b1;
            #1;
            chk("async_reset_values", {gnt, done, start_fetch, reset_addr_counter, buffer_select,
                                       tiles_control, double_buffering, sched_busy, timeout_err}, 0);
            @(posedge clk); #1;
            rst = 1'b0; req = 3'b000; fetch_done = 1'b1;
            m_last = 2; m_pp[0] = 0; m_pp[1] = 0; m_pp[2] = 0; m_to = 1'b0;
            seen = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(posedge clk); #1;
                fetch_done = 1'b0;
                if (done != 3'b000 || sched_busy || gnt != 3'b000) seen = 1'b1;
            end
            chk("no_done_after_abort", seen, 0);
        end

        txn(3'b111, 3'b000, 4, 1'b0, 1'b0, g, b, t);
        chk("rr_after_reset", g, 3'b001);
        req = 3'b000;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
